// File: rtl/uart_receiver_if.sv
// Receive-side bundle of the UART: serial line in, framed byte and status out.
// master is the receiver itself; slave is the byte consumer / line driver.
interface uart_receiver_if;
  logic       RsRx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  modport master (
    input  RsRx,
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output RsRx,
    input  data,
    input  data_valid,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises RsRx, finds the start bit, samples each
// bit at its centre (LSB first), checks the stop bit and pulses the result
// for one clock. CLKS_PER_BIT must be even and at least 4.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_receiver_if.master rx
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic          s0_q, s1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          frame_error_q, frame_error_d;

  // Two-flop synchroniser; resets low so the line must be seen idle before arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= rx.RsRx;
      s1_q <= s0_q;
    end
  end

  // Frame state, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      sh_q          <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state logic: mid-bit sampling driven by the per-bit counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    sh_d          = sh_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        if (s1_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      IDLE: begin
        if (!s1_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (s1_q) begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {s1_q, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (s1_q) begin
            data_d       = sh_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            // Bad stop or break: wait for a high line before rearming.
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = WAIT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx.data        = data_q;
  assign rx.data_valid  = data_valid_q;
  assign rx.frame_error = frame_error_q;
  assign rx.busy        = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
